// File: rtl/nios_system_nios2_cpu_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT frames and hands them downstream over
// valid/ready; also converts test_ending into a sticky test_has_ended once trace drains.
module nios_system_nios2_cpu_oci_dct_packer #(
    parameter int SYM_W        = 2,
    parameter int DEPTH        = 15,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tr_valid,
    input  logic [SYM_W-1:0]      tr_sym,
    output logic                  tr_ready,
    input  logic                  flush,
    output logic                  dct_valid,
    input  logic                  dct_ready,
    output logic [15*SYM_W-1:0]   dct_buffer,
    output logic [3:0]            dct_count,
    input  logic                  test_ending,
    output logic                  test_has_ended
);

    localparam int             BUF_W    = 15 * SYM_W;
    localparam logic [3:0]     DEPTH_C  = 4'(DEPTH);
    localparam logic [7:0]     IDLE_LIM = 8'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [BUF_W-1:0]   buf_nx;
    logic [3:0]         count_nx, count_acc;
    logic               valid_nx, ready_nx, ended_nx;
    logic               ending_q, ending_nx;
    logic [7:0]         idle_q, idle_nx;
    logic               accept, timeout, close;

    always_comb begin
        state_nx  = state;
        buf_nx    = dct_buffer;
        count_nx  = dct_count;
        valid_nx  = dct_valid;
        idle_nx   = '0;
        accept    = 1'b0;
        count_acc = dct_count;
        timeout   = 1'b0;
        close     = 1'b0;
        ending_nx = ending_q | test_ending;

        case (state)
            FILL: begin
                accept = tr_valid & tr_ready;
                if (accept) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (dct_count == 4'(k)) buf_nx[k*SYM_W +: SYM_W] = tr_sym;
                    end
                    count_acc = dct_count + 4'd1;
                end
                // Idle counter only runs while a partial frame is waiting; saturates
                // so a disabled timeout can never wrap back into a match.
                if (!accept && dct_count != 4'd0 && idle_q != 8'hFF) idle_nx = idle_q + 8'd1;
                else if (!accept && dct_count != 4'd0)                idle_nx = idle_q;
                timeout  = (IDLE_TIMEOUT != 0) && (idle_nx == IDLE_LIM);
                close    = (count_acc == DEPTH_C) ||
                           ((flush | ending_nx | timeout) && count_acc != 4'd0);
                count_nx = count_acc;
                if (close) begin
                    state_nx = EMIT;
                    valid_nx = 1'b1;
                    idle_nx  = '0;
                end else if (ending_nx && count_acc == 4'd0) begin
                    state_nx = DONE;
                end
            end
            EMIT: begin
                if (dct_ready) begin
                    buf_nx   = '0;
                    count_nx = '0;
                    valid_nx = 1'b0;
                    state_nx = ending_nx ? DONE : FILL;
                end
            end
            DONE: begin
                valid_nx = 1'b0;
            end
            default: begin
                state_nx = FILL;
                valid_nx = 1'b0;
            end
        endcase

        // Requiring FILL on both sides of the edge yields the single bubble after a handoff.
        ready_nx = (state == FILL) && (state_nx == FILL) && !ending_nx;
        ended_nx = test_has_ended | (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= FILL;
            dct_buffer     <= '0;
            dct_count      <= '0;
            dct_valid      <= 1'b0;
            tr_ready       <= 1'b0;
            test_has_ended <= 1'b0;
            idle_q         <= '0;
            ending_q       <= 1'b0;
        end else begin
            state          <= state_nx;
            dct_buffer     <= buf_nx;
            dct_count      <= count_nx;
            dct_valid      <= valid_nx;
            tr_ready       <= ready_nx;
            test_has_ended <= ended_nx;
            idle_q         <= idle_nx;
            ending_q       <= ending_nx;
        end
    end

endmodule

// File: tb/tb_nios_system_nios2_cpu_oci_dct_packer.sv
// Randomized and directed bench for the DCT packer against a queue-based frame model.
module tb_nios_system_nios2_cpu_oci_dct_packer;

    localparam int DEPTH        = 15;
    localparam int IDLE_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tr_valid;
    logic [1:0]  tr_sym;
    logic        tr_ready;
    logic        flush;
    logic        dct_valid;
    logic        dct_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    nios_system_nios2_cpu_oci_dct_packer #(
        .SYM_W(2), .DEPTH(DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .tr_valid(tr_valid), .tr_sym(tr_sym), .tr_ready(tr_ready),
        .flush(flush),
        .dct_valid(dct_valid), .dct_ready(dct_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 = filling, 1 = frame on offer, 2 = ended
    int m_mode;
    int q[$];
    bit m_ready;
    int m_idle;
    bit m_end;
    bit m_ended;

    function automatic logic [29:0] pack();
        logic [29:0] r;
        r = '0;
        foreach (q[k]) r |= 30'(q[k]) << (2 * k);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; q.delete(); m_ready = 0; m_idle = 0; m_end = 0; m_ended = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_tr_ready"},  32'(tr_ready),       32'(m_ready));
        check({pfx, "_dct_valid"}, 32'(dct_valid),      32'(m_mode == 1));
        check({pfx, "_dct_count"}, 32'(dct_count),      32'(q.size()));
        check({pfx, "_dct_buf"},   32'(dct_buffer),     32'(pack()));
        check({pfx, "_ended"},     32'(test_has_ended), 32'(m_ended));
    endtask

    task automatic step();
        bit acc, end_n;
        int old_mode;
        acc      = (m_mode == 0) && tr_valid && m_ready;
        end_n    = m_end || test_ending;
        old_mode = m_mode;
        if (acc) q.push_back(int'(tr_sym));
        case (m_mode)
            0: begin
                if (!acc && q.size() > 0) m_idle++;
                else                      m_idle = 0;
                if (q.size() == DEPTH ||
                    ((flush || end_n || (IDLE_TIMEOUT != 0 && m_idle == IDLE_TIMEOUT)) && q.size() > 0)) begin
                    m_mode = 1; m_idle = 0;
                end else if (end_n && q.size() == 0) begin
                    m_mode = 2;
                end
            end
            1: if (dct_ready) begin q.delete(); m_mode = end_n ? 2 : 0; end
            default: ;
        endcase
        m_ready = (old_mode == 0) && (m_mode == 0) && !end_n;
        m_end   = end_n;
        if (m_mode == 2) m_ended = 1;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic send_sym(input logic [1:0] s);
        tr_valid = 1'b1;
        tr_sym   = s;
        for (int i = 0; i < 300 && !tr_ready; i++) step();
        check("send_ready", 32'(tr_ready), 32'd1);
        step();
        tr_valid = 1'b0;
    endtask

    task automatic do_reset();
        tr_valid = 0; flush = 0; test_ending = 0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [29:0] exp_buf;
    int          n_idle;

    initial begin
        reset_n = 1'b0; tr_valid = 0; tr_sym = 0; flush = 0; dct_ready = 0; test_ending = 0;
        model_reset();
        #2;
        check_outputs("init");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        check("first_ready", 32'(tr_ready), 32'd1);

        // Full frame with immediate acceptance.
        dct_ready = 1'b1;
        for (int k = 0; k < 15; k++) send_sym(2'(k % 4));
        check("full_valid", 32'(dct_valid), 32'd1);
        check("full_count", 32'(dct_count), 32'd15);
        check("full_buf",   32'(dct_buffer), 32'h24E4E4E4);
        check("full_rdy_emit", 32'(tr_ready), 32'd0);
        step();
        check("handoff_valid", 32'(dct_valid), 32'd0);
        check("bubble_rdy", 32'(tr_ready), 32'd0);
        step();
        check("resume_rdy", 32'(tr_ready), 32'd1);

        // Flush on empty, then a short flushed frame.
        dct_ready = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_empty", 32'(dct_valid), 32'd0);
        send_sym(2'd3); send_sym(2'd1); send_sym(2'd2);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_valid", 32'(dct_valid), 32'd1);
        check("flush_count", 32'(dct_count), 32'd3);
        check("flush_buf",   32'(dct_buffer), 32'h27);
        dct_ready = 1'b1; step(); step();

        // Backpressure on a full frame with symbols still offered.
        dct_ready = 1'b0;
        exp_buf = '0;
        for (int k = 0; k < 15; k++) begin
            tr_sym = 2'($urandom_range(0, 3));
            exp_buf |= 30'(tr_sym) << (2 * k);
            send_sym(tr_sym);
        end
        tr_valid = 1'b1; tr_sym = 2'd1;
        for (int i = 0; i < 10; i++) step();
        check("bp_valid", 32'(dct_valid), 32'd1);
        check("bp_count", 32'(dct_count), 32'd15);
        check("bp_buf",   32'(dct_buffer), 32'(exp_buf));
        dct_ready = 1'b1;
        step();
        check("bp_handoff_count", 32'(dct_count), 32'd0);
        step();
        check("bp_bubble_count", 32'(dct_count), 32'd0);
        step();
        check("bp_resume_count", 32'(dct_count), 32'd1);
        tr_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0; step();

        // Idle timeout on a partial frame.
        dct_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_sym(2'(k));
        n_idle = 0;
        for (int i = 0; i < 300 && !dct_valid; i++) begin step(); n_idle++; end
        check("idle_cycles", 32'(n_idle), 32'd64);
        check("idle_count",  32'(dct_count), 32'd5);
        dct_ready = 1'b1; step(); step();

        // test_ending with a partial frame pending.
        for (int k = 0; k < 4; k++) send_sym(2'(3 - k));
        dct_ready = 1'b0;
        test_ending = 1'b1; step(); test_ending = 1'b0;
        check("end_rdy",   32'(tr_ready), 32'd0);
        check("end_valid", 32'(dct_valid), 32'd1);
        check("end_count", 32'(dct_count), 32'd4);
        check("end_not_yet", 32'(test_has_ended), 32'd0);
        dct_ready = 1'b1; step();
        check("end_has_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("end_sticky", 32'(test_has_ended), 32'd1);
        do_reset(); step();

        // test_ending on an empty packer.
        test_ending = 1'b1; step(); test_ending = 1'b0;
        check("end0_ended", 32'(test_has_ended), 32'd1);
        check("end0_valid", 32'(dct_valid), 32'd0);
        do_reset(); step();

        // Reset while a frame is on offer.
        dct_ready = 1'b0;
        send_sym(2'd2); send_sym(2'd1);
        flush = 1'b1; step(); flush = 1'b0;
        check("pre_rst_valid", 32'(dct_valid), 32'd1);
        do_reset();
        check("rst_mid_valid", 32'(dct_valid), 32'd0);
        check("rst_mid_buf",   32'(dct_buffer), 32'd0);
        step();
        send_sym(2'd3);
        check("post_rst_buf",   32'(dct_buffer), 32'd3);
        check("post_rst_count", 32'(dct_count), 32'd1);

        // Randomized traffic.
        for (int ep = 0; ep < 20; ep++) begin
            int pv, pr;
            int done_cnt;
            case (ep % 4)
                0: pv = 90;
                1: pv = 50;
                2: pv = 10;
                default: pv = 1;
            endcase
            pr = (ep % 3 == 0) ? 20 : ((ep % 3 == 1) ? 70 : 100);
            done_cnt = 0;
            for (int c = 0; c < 150; c++) begin
                tr_valid    = ($urandom_range(0, 99) < pv);
                tr_sym      = 2'($urandom_range(0, 3));
                dct_ready   = ($urandom_range(0, 99) < pr);
                flush       = ($urandom_range(0, 99) < 3);
                test_ending = ($urandom_range(0, 999) < 3);
                if ($urandom_range(0, 999) < 4) begin
                    do_reset();
                end else begin
                    step();
                end
                if (m_mode == 2) done_cnt++;
                if (done_cnt > 5) begin
                    done_cnt = 0;
                    do_reset();
                end
            end
            tr_valid = 0; flush = 0; test_ending = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_system_nios2_cpu_oci_dct_packer.md
Name: nios_system_Nios2_cpu_oci_dct_packer

Overview:
Upstream stage of the OCI data-capture-trace (DCT) consumer. Packs a stream of 2-bit trace symbols into 30-bit DCT frames (up to 15 symbols) with a 4-bit valid-symbol count. Presents each frame through a valid/ready handshake to the downstream DCT consumer. Also drives the end-of-test handshake: it turns test_ending into test_has_ended once every pending trace has drained.

Parameters:
SYM_W, 2, bits per trace symbol; fixed at 2 (buffer = 15 x SYM_W = 30 bits)
DEPTH, 15, symbols per full frame; legal range 1..15
IDLE_TIMEOUT, 64, idle cycles before a partial frame auto-flushes; 0 disables; legal range 0..255

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
tr_valid  input  1  trace symbol valid
tr_sym  input  2  trace symbol
tr_ready  output  1  packer can accept a symbol this cycle
flush  input  1  single-cycle request to close the current partial frame
dct_valid  output  1  frame presented
dct_ready  input  1  downstream accepts frame
dct_buffer  output  30  packed frame; symbol k at bits [2k+1:2k]; unused bits 0
dct_count  output  4  number of valid symbols in dct_buffer (1..DEPTH while dct_valid)
test_ending  input  1  end-of-test request (level or pulse; latched)
test_has_ended  output  1  sticky: all trace drained after test_ending

Behaviour:
- Reset (async, reset_n=0) sets state FILL, dct_buffer=0, dct_count=0, dct_valid=0, tr_ready=0, test_has_ended=0, idle counter=0, ending latch=0. tr_ready rises on the first clock after reset_n deasserts.
- State FILL:
  - tr_ready=1 unless the ending latch is set.
  - A symbol is accepted when tr_valid & tr_ready. It is written at slot dct_count and dct_count increments. Latency to buffer: 1 cycle.
- Close condition, evaluated after any same-cycle acceptance:
  - count reaches DEPTH, or
  - (flush | ending latch | idle timeout) with count > 0.
  - On close: next state EMIT, dct_valid=1.
- flush with count=0 is ignored, and no empty frame is ever emitted. A symbol accepted in the same cycle as flush is included in the closed frame.
- Idle counter:
  - Increments each FILL cycle with count>0 and no accepted symbol.
  - Clears on any accept or on leaving FILL.
  - Reaching IDLE_TIMEOUT counts as a flush.
- State EMIT:
  - tr_ready=0; dct_buffer, dct_count and dct_valid are held stable until dct_ready.
  - On dct_valid & dct_ready: buffer and count clear to 0, dct_valid drops next cycle.
  - Next state is DONE if the ending latch is set, else FILL.
  - There is one bubble cycle: no symbol is accepted in the handoff cycle.
- Ending latch:
  - Set on any cycle with test_ending=1; cleared only by reset.
  - Once set, tr_ready=0 from the next cycle on.
  - If set in FILL with count=0, next state is DONE.
- State DONE: tr_ready=0, dct_valid=0, test_has_ended=1 (registered, asserted the cycle DONE is entered, sticky).
- dct_count never exceeds DEPTH, with no wrap. A symbol offered when the frame is full is not accepted because tr_ready=0.
- Reset mid-EMIT discards the frame: outputs return to reset values immediately, with no partial handoff.
- dct_ready without dct_valid has no effect.

Test Plan:
- 15 symbols, tr_sym=k mod 4 for k=0..14, dct_ready=1 -> one frame, dct_count=15, dct_buffer=30'h24E4E4E4 (slot k=k mod 4), tr_ready low for exactly the EMIT and handoff cycles.
- 3 symbols {3,1,2} then flush -> dct_count=3, dct_buffer=30'h27. Also flush with count=0 -> dct_valid stays 0.
- Full frame with dct_ready held 0 for 10 cycles, with tr_valid=1 throughout -> buffer, count and valid stable, no symbol accepted. Release dct_ready -> handoff, then symbols resume 2 cycles later.
- 5 symbols then idle, IDLE_TIMEOUT=64 -> dct_valid asserts 64 cycles after the last accept, dct_count=5.
- test_ending pulse with count=4 -> tr_ready drops, frame with count=4 emitted, test_has_ended=1 the cycle after handoff and stays 1. test_ending with count=0 -> test_has_ended=1 after 1 cycle, no frame.
- reset_n asserted mid-EMIT -> dct_valid=0, dct_count=0, dct_buffer=0 asynchronously. After release -> fresh FILL, first symbol lands in slot 0.
